// File: rtl/cpu_pkg.sv
// Purpose : shared instruction-field and fetch-state definitions for the CPU front end.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: instruction-type codes, type-field geometry, fetch FSM state enum.
package cpu_pkg;

  // Instruction-type codes carried in the top TYPE_W bits of every instruction.
  localparam logic [1:0] TYPE_CTRL = 2'b00;
  localparam logic [1:0] TYPE_MEM  = 2'b01;
  localparam logic [1:0] TYPE_DATA = 2'b10;
  localparam logic [1:0] TYPE_HALT = 2'b11;

  // The type field occupies the most significant TYPE_W bits.
  // Select it with instr[INSTR_W-1 -: TYPE_W].
  localparam int TYPE_W = 2;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Purpose : program-counter register with a load (redirect) path and an enable (advance) path.
// Latency : one cycle from load/en to q.
// Backpressure: en=0 holds the value; load has priority over en.
// Ports   : clk, rst (async active-low), load/load_val, en/d, q.
module pc_reg #(
  parameter int            W         = 32,
  parameter logic [W-1:0]  RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Purpose : instruction fetch stage; holds the PC, addresses the async ROM, fills the IF/ID register.
// Latency : instruction at pc appears on id_instr one cycle later; a redirect costs one bubble.
// Backpressure: stall freezes PC and IF/ID; redirect overrides stall and HALT.
// Ports   : clk, rst (async active-low); imem_addr/imem_data ROM port; stall; jump_i/jump_ci/jump_cd,
//           alu_zero, jump_target redirect inputs; id_instr/id_pc_plus/id_valid IF/ID outputs; halted.
// Option  : FETCH_PERF_EN adds perf_fetched and perf_bubbles counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               stall,
  input  logic               jump_i,
  input  logic               jump_ci,
  input  logic               jump_cd,
  input  logic               alu_zero,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc_plus,
  output logic               id_valid,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus;
  logic              redirect;
  logic              fetch_go;
  logic              is_halt;
  logic              pc_en;

  assign redirect  = jump_i | (jump_ci & alu_zero) | (jump_cd & ~alu_zero);
  assign pc_plus   = pc + ADDR_W'(PC_STEP);   // wraps modulo 2^ADDR_W
  assign imem_addr = pc;
  assign is_halt   = (imem_data[INSTR_W-1 -: TYPE_W] == TYPE_HALT);

  // A fetch happens only in RUN with no stall and no redirect.
  assign fetch_go  = (state == RUN) & ~stall & ~redirect;
  // A fetched halt instruction is captured but the PC stays on it.
  assign pc_en     = fetch_go & ~is_halt;

  pc_reg #(
    .W         (ADDR_W),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (redirect),
    .load_val (jump_target),
    .en       (pc_en),
    .d        (pc_plus),
    .q        (pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      id_instr   <= '0;
      id_pc_plus <= '0;
      id_valid   <= 1'b0;
      halted     <= 1'b0;
    end else if (redirect) begin
      state      <= RUN;
      id_instr   <= '0;
      id_pc_plus <= '0;
      id_valid   <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        HALT: begin
          // The halt instruction was presented once; keep IF/ID empty from now on.
          id_instr   <= '0;
          id_pc_plus <= '0;
          id_valid   <= 1'b0;
        end
        RUN: begin
          if (!stall) begin
            id_instr   <= imem_data;
            id_pc_plus <= pc_plus;
            id_valid   <= 1'b1;
            if (is_halt) begin
              state  <= HALT;
              halted <= 1'b1;
            end
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (fetch_go) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if ((stall | redirect) && (state != HALT)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vectors, an abstract reference model, and
// a negedge compare process plus hand-computed literal expectations.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        jump_i;
  logic        jump_ci;
  logic        jump_cd;
  logic        alu_zero;
  logic [31:0] jump_target;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus;
  logic        id_valid;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  localparam logic [31:0] INSTR_A = 32'h1234_5678;
  localparam logic [31:0] INSTR_B = 32'h5000_0001;
  localparam logic [31:0] INSTR_H = 32'hC000_0010;

  // ROM contents: a few fixed words, everything else type 2'b10 tagged with its address.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0000: rom = INSTR_A;
      32'h0000_0004: rom = INSTR_B;
      32'h0000_0010: rom = INSTR_H;
      default:       rom = {2'b10, 6'h00, a[23:0]};
    endcase
  endfunction

  assign imem_data = rom(imem_addr);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .stall       (stall),
    .jump_i      (jump_i),
    .jump_ci     (jump_ci),
    .jump_cd     (jump_cd),
    .alu_zero    (alu_zero),
    .jump_target (jump_target),
    .id_instr    (id_instr),
    .id_pc_plus  (id_pc_plus),
    .id_valid    (id_valid),
    .halted      (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the address being fetched, the mode
  // (0 = first cycle after reset, 1 = fetching, 2 = halted) and the expected IF/ID contents.
  logic [31:0] m_pc     = 32'h0;
  int          m_mode   = 0;
  logic [31:0] m_instr  = 32'h0;
  logic [31:0] m_plus   = 32'h0;
  logic        m_valid  = 1'b0;
  logic [31:0] m_fetched = 32'h0;
  logic [31:0] m_bubbles = 32'h0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pc = 32'h0; m_mode = 0; m_instr = 32'h0; m_plus = 32'h0; m_valid = 1'b0;
      m_fetched = 32'h0; m_bubbles = 32'h0;
    end else begin
      logic        jmp;
      logic [31:0] w;
      jmp = jump_i || (jump_ci && alu_zero) || (jump_cd && !alu_zero);
      if ((stall || jmp) && m_mode != 2) m_bubbles = m_bubbles + 1;
      if (jmp) begin
        m_pc = jump_target; m_mode = 1; m_valid = 1'b0; m_instr = 32'h0; m_plus = 32'h0;
      end else if (m_mode == 0) begin
        m_mode = 1;
      end else if (m_mode == 2) begin
        m_valid = 1'b0; m_instr = 32'h0; m_plus = 32'h0;
      end else if (!stall) begin
        w = rom(m_pc);
        m_instr = w; m_plus = m_pc + 32'd4; m_valid = 1'b1;
        m_fetched = m_fetched + 1;
        if (w[31:30] == 2'b11) m_mode = 2;
        else m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_addr",  imem_addr, m_pc);
      chk("m_valid", {31'h0, id_valid}, {31'h0, m_valid});
      chk("m_instr", id_instr, m_instr);
      if (m_valid) chk("m_plus", id_pc_plus, m_plus);
      chk("m_halted", {31'h0, halted}, {31'h0, (m_mode == 2)});
`ifdef FETCH_PERF_EN
      chk("m_perf_fetched", perf_fetched, m_fetched);
      chk("m_perf_bubbles", perf_bubbles, m_bubbles);
`endif
    end
  end

  // Advance one clock; outputs are settled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_jumps();
    jump_i = 1'b0; jump_ci = 1'b0; jump_cd = 1'b0; alu_zero = 1'b0; jump_target = 32'h0;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0;
    clr_jumps();
    #12;
    chk("rst_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    @(posedge clk); #2;
    rst = 1'b1;
    cmp_en = 1'b1;

    // BOOT cycle, then A and B.
    tick();
    chk("boot_valid", {31'h0, id_valid}, 32'h0);
    chk("boot_addr",  imem_addr, 32'h0);
    tick();
    chk("a_instr", id_instr, INSTR_A);
    chk("a_plus",  id_pc_plus, 32'h4);
    tick();
    chk("b_instr", id_instr, INSTR_B);
    chk("b_plus",  id_pc_plus, 32'h8);
    chk("b_addr",  imem_addr, 32'h8);

    // Stall three cycles at pc=8.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_addr",  imem_addr, 32'h8);
      chk("stall_instr", id_instr, INSTR_B);
    end
    stall = 1'b0;
    tick();
    chk("resume_instr", id_instr, 32'h8000_0008);
    chk("resume_plus",  id_pc_plus, 32'hC);
    chk("resume_addr",  imem_addr, 32'hC);

    // Conditional-on-zero redirect to 0x40.
    jump_ci = 1'b1; alu_zero = 1'b1; jump_target = 32'h40;
    tick();
    clr_jumps();
    chk("jci_addr",  imem_addr, 32'h40);
    chk("jci_valid", {31'h0, id_valid}, 32'h0);
    tick();
    chk("jci_instr", id_instr, 32'h8000_0040);
    chk("jci_plus",  id_pc_plus, 32'h44);

    // jump_cd with alu_zero=1: no redirect.
    jump_cd = 1'b1; alu_zero = 1'b1; jump_target = 32'h200;
    tick();
    clr_jumps();
    chk("jcd_no_valid", {31'h0, id_valid}, 32'h1);
    chk("jcd_no_addr",  imem_addr, 32'h48);

    // jump_cd with alu_zero=0 plus jump_ci together: OR rule redirects.
    jump_cd = 1'b1; jump_ci = 1'b1; alu_zero = 1'b0; jump_target = 32'h60;
    tick();
    clr_jumps();
    chk("jcd_addr",  imem_addr, 32'h60);
    chk("jcd_valid", {31'h0, id_valid}, 32'h0);

    // Stall and jump together: redirect wins.
    stall = 1'b1; jump_i = 1'b1; jump_target = 32'h80;
    tick();
    clr_jumps(); stall = 1'b0;
    chk("sj_addr",  imem_addr, 32'h80);
    chk("sj_valid", {31'h0, id_valid}, 32'h0);
    tick();
    chk("sj_instr", id_instr, 32'h8000_0080);

    // PC wrap at the top of the address space.
    jump_i = 1'b1; jump_target = 32'hFFFF_FFFC;
    tick();
    clr_jumps();
    tick();
    chk("wrap_instr", id_instr, 32'h80FF_FFFC);
    chk("wrap_plus",  id_pc_plus, 32'h0);
    chk("wrap_addr",  imem_addr, 32'h0);

    // Redirect to the halt instruction.
    jump_i = 1'b1; jump_target = 32'h10;
    tick();
    clr_jumps();
    tick();
    chk("halt_instr",  id_instr, INSTR_H);
    chk("halt_valid",  {31'h0, id_valid}, 32'h1);
    chk("halt_plus",   id_pc_plus, 32'h14);
    chk("halt_flag",   {31'h0, halted}, 32'h1);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("halt_hold_addr",  imem_addr, 32'h10);
      chk("halt_hold_valid", {31'h0, id_valid}, 32'h0);
      chk("halt_hold_flag",  {31'h0, halted}, 32'h1);
    end
    stall = 1'b0;
    jump_i = 1'b1; jump_target = 32'h18;
    tick();
    clr_jumps();
    chk("unhalt_flag", {31'h0, halted}, 32'h0);
    chk("unhalt_addr", imem_addr, 32'h18);
    tick();
    tick();
    chk("run20_addr", imem_addr, 32'h20);

    // Asynchronous reset mid-run at pc=0x20.
    rst = 1'b0;
    #1;
    chk("arst_valid", {31'h0, id_valid}, 32'h0);
    chk("arst_instr", id_instr, 32'h0);
    chk("arst_addr",  imem_addr, 32'h0);
    chk("arst_plus",  id_pc_plus, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("reboot_valid", {31'h0, id_valid}, 32'h0);
    chk("reboot_addr",  imem_addr, 32'h0);
    tick();
    chk("reboot_a", id_instr, INSTR_A);
    tick();
    tick();

    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
